// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP weight loader: weight type, loader FSM states, error codes.
package mlp_pkg;

    localparam int N_WEIGHTS_DEF = 9;
    localparam int W_WIDTH_DEF   = 4;

    typedef logic [W_WIDTH_DEF-1:0] weight_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DRAIN  = 3'd4
    } loader_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_SHORT = 2'b01,
        ERR_LONG  = 2'b10,
        ERR_CSUM  = 2'b11
    } err_code_e;

endpackage

// File: rtl/mlp_weight_bank.sv
// Double-buffered weight storage: a shadow bank written word by word and an active bank
// that takes the whole shadow bank in one cycle on commit.
module mlp_weight_bank #(
    parameter int N_WEIGHTS = 9,
    parameter int W_WIDTH   = 4,
    parameter int IDX_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [W_WIDTH-1:0] wr_data,
    input  logic               wr_en,
    input  logic               commit,
    output logic [W_WIDTH-1:0] w [N_WEIGHTS-1:0]
);

    logic [W_WIDTH-1:0] shadow_r [N_WEIGHTS-1:0];

    // Shadow bank: written one word per accepted stream beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WEIGHTS; i++) begin
                shadow_r[i] <= {W_WIDTH{1'b0}};
            end
        end else if (wr_en && (wr_idx < IDX_W'(N_WEIGHTS))) begin
            shadow_r[wr_idx] <= wr_data;
        end
    end

    // Active bank: atomic copy of the shadow bank, otherwise held indefinitely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WEIGHTS; i++) begin
                w[i] <= {W_WIDTH{1'b0}};
            end
        end else if (commit) begin
            for (int i = 0; i < N_WEIGHTS; i++) begin
                w[i] <= shadow_r[i];
            end
        end
    end

endmodule

// File: rtl/mlp_weight_loader.sv
// Stream-to-parallel MLP weight loader with frame length checking and atomic commit.
// Optional feature macro MLP_WLOAD_CHECKSUM_EN: frame carries a trailing checksum word.
module mlp_weight_loader
    import mlp_pkg::*;
#(
    parameter int N_WEIGHTS = N_WEIGHTS_DEF,
    parameter int W_WIDTH   = W_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W_WIDTH-1:0] s_data,
    input  logic               s_last,
    output logic [W_WIDTH-1:0] w [N_WEIGHTS-1:0],
    output logic               w_valid,
    output logic               w_update,
    output logic               err,
    output logic [1:0]         err_code
);

`ifdef MLP_WLOAD_CHECKSUM_EN
    localparam int FRAME_LEN = N_WEIGHTS + 1;
`else
    localparam int FRAME_LEN = N_WEIGHTS;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN + 1);

    loader_state_e      state_r;
    loader_state_e      state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic [W_WIDTH-1:0] sum_r;
    logic [W_WIDTH-1:0] chk_r;
    logic               accept_s;
    logic               frame_end_s;
    logic               shadow_we_s;
    logic               commit_s;
    logic               err_set_s;
    err_code_e          err_code_set_s;

    assign accept_s    = s_valid & s_ready;
    assign frame_end_s = (idx_r == IDX_W'(FRAME_LEN - 1));

    mlp_weight_bank #(
        .N_WEIGHTS (N_WEIGHTS),
        .W_WIDTH   (W_WIDTH),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_idx  (idx_r),
        .wr_data (s_data),
        .wr_en   (shadow_we_s),
        .commit  (commit_s),
        .w       (w)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_next_s   = state_r;
        shadow_we_s    = 1'b0;
        commit_s       = 1'b0;
        err_set_s      = 1'b0;
        err_code_set_s = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    shadow_we_s = 1'b1;
                    if (s_last) begin
                        err_set_s      = 1'b1;
                        err_code_set_s = ERR_SHORT;
                        state_next_s   = ST_IDLE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    // the checksum word (index N_WEIGHTS) never lands in the shadow bank
                    shadow_we_s = (idx_r < IDX_W'(N_WEIGHTS));
                    if (frame_end_s) begin
                        if (s_last) begin
`ifdef MLP_WLOAD_CHECKSUM_EN
                            state_next_s = ST_CHECK;
`else
                            state_next_s = ST_COMMIT;
`endif
                        end else begin
                            err_set_s      = 1'b1;
                            err_code_set_s = ERR_LONG;
                            state_next_s   = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        err_set_s      = 1'b1;
                        err_code_set_s = ERR_SHORT;
                        state_next_s   = ST_IDLE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_CHECK: begin
                if (sum_r == chk_r) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    err_set_s      = 1'b1;
                    err_code_set_s = ERR_CSUM;
                    state_next_s   = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                commit_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (accept_s && s_last) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: word index, running checksum, registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r    <= {IDX_W{1'b0}};
            sum_r    <= {W_WIDTH{1'b0}};
            chk_r    <= {W_WIDTH{1'b0}};
            s_ready  <= 1'b0;
            w_valid  <= 1'b0;
            w_update <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            s_ready  <= (state_next_s != ST_CHECK) && (state_next_s != ST_COMMIT);
            w_update <= commit_s;
            err      <= err_set_s;
            if (err_set_s) begin
                err_code <= err_code_set_s;
            end
            if (commit_s) begin
                w_valid <= 1'b1;
            end
            if (state_next_s != ST_FILL) begin
                idx_r <= {IDX_W{1'b0}};
            end else if (accept_s) begin
                idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (shadow_we_s) begin
                sum_r <= (state_r == ST_IDLE) ? s_data : (sum_r + s_data);
            end
            if (accept_s && (state_r == ST_FILL) && (idx_r == IDX_W'(N_WEIGHTS))) begin
                chk_r <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Directed self-checking bench for mlp_weight_loader (default build; adapts to MLP_WLOAD_CHECKSUM_EN).
module tb_mlp_weight_loader;

`ifdef MLP_WLOAD_CHECKSUM_EN
    localparam int FLEN = 10;
    localparam int LAT  = 2;
`else
    localparam int FLEN = 9;
    localparam int LAT  = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       s_last;
    logic [3:0] w [8:0];
    logic       w_valid;
    logic       w_update;
    logic       err;
    logic [1:0] err_code;

    int n_tests;
    int n_fail;
    int err_cnt;
    int upd_cnt;
    int e0;
    int u0;
    int err_idx;
    logic last_err;

    mlp_weight_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .w        (w),
        .w_valid  (w_valid),
        .w_update (w_update),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: a one-cycle pulse adds exactly one
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (w_update === 1'b1) upd_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag, input bit zero);
        for (int i = 0; i < 9; i++) begin
            check_val($sformatf("%s_w%0d", tag, i), {28'd0, w[i]}, zero ? 32'd0 : 32'(i + 1));
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_word(input logic [3:0] d, input logic l, input int gap);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        last_err = err;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_good_frame(input int gap);
        for (int i = 0; i < 9; i++) begin
`ifdef MLP_WLOAD_CHECKSUM_EN
            send_word(4'(i + 1), 1'b0, (i == 8) ? 0 : gap);
`else
            send_word(4'(i + 1), (i == 8), (i == 8) ? 0 : gap);
`endif
        end
`ifdef MLP_WLOAD_CHECKSUM_EN
        send_word(4'hD, 1'b1, 0);
`endif
    endtask

    initial begin
        n_tests = 0; n_fail = 0; err_cnt = 0; upd_cnt = 0; err_idx = 0;
        last_err = 1'b0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 4'd0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, s_ready}, 32'd0);
        check_val("rst_wvalid", {31'd0, w_valid}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_code", {30'd0, err_code}, 32'd0);
        check_bank("rst", 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full frame, commit latency and one-cycle update pulse
        send_good_frame(0);
        repeat (LAT - 1) @(negedge clk);
        check_val("t1_ready_bubble", {31'd0, s_ready}, 32'd0);
        check_val("t1_no_early_upd", {31'd0, w_update}, 32'd0);
        check_val("t1_w8_old", {28'd0, w[8]}, 32'd0);
        @(negedge clk);
        check_val("t1_upd", {31'd0, w_update}, 32'd1);
        check_val("t1_wvalid", {31'd0, w_valid}, 32'd1);
        check_bank("t1", 1'b0);
        @(negedge clk);
        check_val("t1_upd_end", {31'd0, w_update}, 32'd0);
        check_val("t1_ready_back", {31'd0, s_ready}, 32'd1);
        check_val("t1_upd_cnt", 32'(upd_cnt), 32'd1);

        // 2: short frame of 5 words
        e0 = err_cnt; u0 = upd_cnt;
        for (int i = 0; i < 5; i++) send_word(4'(i + 11), (i == 4), 0);
        check_val("t2_err", {31'd0, last_err}, 32'd1);
        check_val("t2_code", {30'd0, err_code}, 32'd1);
        repeat (3) @(negedge clk);
        check_val("t2_err_cnt", 32'(err_cnt - e0), 32'd1);
        check_val("t2_no_upd", 32'(upd_cnt - u0), 32'd0);
        check_bank("t2", 1'b0);

        // 3: long frame of 12 words, error on the frame-length accept, rest drained
        e0 = err_cnt; u0 = upd_cnt; err_idx = 0;
        for (int i = 0; i < 12; i++) begin
            send_word(4'(i + 3), (i == 11), 0);
            if (last_err === 1'b1 && err_idx == 0) err_idx = i + 1;
        end
        repeat (3) @(negedge clk);
        check_val("t3_err_idx", 32'(err_idx), 32'(FLEN));
        check_val("t3_code", {30'd0, err_code}, 32'd2);
        check_val("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
        check_val("t3_no_upd", 32'(upd_cnt - u0), 32'd0);
        check_bank("t3", 1'b0);

        // single-word frame with s_last
        e0 = err_cnt;
        send_word(4'h7, 1'b1, 0);
        check_val("sw_err", {31'd0, last_err}, 32'd1);
        check_val("sw_code", {30'd0, err_code}, 32'd1);
        @(negedge clk);
        check_val("sw_err_cnt", 32'(err_cnt - e0), 32'd1);

        // 5: reset after 4 words of a frame
        for (int i = 0; i < 4; i++) send_word(4'(i + 5), 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_wvalid", {31'd0, w_valid}, 32'd0);
        check_val("t5_ready", {31'd0, s_ready}, 32'd0);
        check_val("t5_code", {30'd0, err_code}, 32'd0);
        check_bank("t5", 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 4: s_valid toggling every other cycle, frame must load after the reset
        e0 = err_cnt; u0 = upd_cnt;
        send_good_frame(1);
        repeat (LAT + 2) @(negedge clk);
        check_val("t4_upd_cnt", 32'(upd_cnt - u0), 32'd1);
        check_val("t4_err_cnt", 32'(err_cnt - e0), 32'd0);
        check_val("t4_wvalid", {31'd0, w_valid}, 32'd1);
        check_bank("t4", 1'b0);

`ifdef MLP_WLOAD_CHECKSUM_EN
        // 6: wrong checksum rejected, weights untouched
        e0 = err_cnt; u0 = upd_cnt;
        for (int i = 0; i < 9; i++) send_word(4'(15 - i), 1'b0, 0);
        send_word(4'h0, 1'b1, 0);
        repeat (3) @(negedge clk);
        check_val("t6_err_cnt", 32'(err_cnt - e0), 32'd1);
        check_val("t6_code", {30'd0, err_code}, 32'd3);
        check_val("t6_no_upd", 32'(upd_cnt - u0), 32'd0);
        check_bank("t6", 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
